// File: rtl/tmds_gearbox_if.sv
// Lane-parallel symbol input and lockstep narrow output bundle for tmds_gearbox.
// The source side drives symbols and bitslip. The gearbox side returns ready,
// the serializer beats and the status signals.
interface tmds_gearbox_if #(
    parameter int NUM_CH = 4,
    parameter int IN_W   = 10,
    parameter int OUT_W  = 4
);
    localparam int LVL_W = $clog2(2 * IN_W + 1);

    logic [NUM_CH*IN_W-1:0]  i_pdata;
    logic                    i_valid;
    logic                    o_ready;
    logic                    i_bitslip;
    logic [NUM_CH*OUT_W-1:0] o_sdata;
    logic                    o_sdata_valid;
    logic                    o_underflow;
    logic [LVL_W-1:0]        o_level;

    modport master (
        output i_pdata, i_valid, i_bitslip,
        input  o_ready, o_sdata, o_sdata_valid, o_underflow, o_level
    );

    modport slave (
        input  i_pdata, i_valid, i_bitslip,
        output o_ready, o_sdata, o_sdata_valid, o_underflow, o_level
    );
endinterface

// File: rtl/tmds_gearbox.sv
// Multi-lane IN_W -> OUT_W gearbox in front of the HDMI serializers.
// All lanes share a single bit count, so every lane pops and pushes in lockstep.
// Each lane buffer holds its oldest bit at index 0. A pop shifts the buffer right.
// A push ORs the new symbol in directly above the bits that remain after the pop.
//
//  state   | meaning
//  --------+-----------------------------------------------------------------
//  ST_FILL | priming or recovering; a missing pop here is not an underflow
//  ST_RUN  | streaming; the first edge without a pop sets the sticky underflow
module tmds_gearbox #(
    parameter int NUM_CH    = 4,
    parameter int IN_W      = 10,
    parameter int OUT_W     = 4,
    parameter int LSB_FIRST = 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    tmds_gearbox_if.slave bus
);
    localparam int CAP   = 2 * IN_W;
    localparam int LVL_W = $clog2(CAP + 1);
    // One extra bit so that level + IN_W cannot wrap in the room check.
    localparam int CW    = LVL_W + 1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [LVL_W-1:0]        cnt_q, cnt_d;
    logic                    slip_q, slip_d;
    logic [CAP-1:0]          buf_q [NUM_CH];
    logic [CAP-1:0]          buf_d [NUM_CH];
    logic [IN_W-1:0]         sym   [NUM_CH];
    logic [NUM_CH*OUT_W-1:0] sdata_q, sdata_d;
    logic                    sdata_valid_q;
    logic                    underflow_q, underflow_d;

    logic [CW-1:0]           take;
    logic [CW-1:0]           popped;
    logic [CW-1:0]           after_pop;
    logic                    pop;
    logic                    push;
    logic                    ready;

    // Pop/push decision from the start-of-cycle level.
    // A pending slip costs one extra bit on the next pop.
    always_comb begin
        take      = CW'(OUT_W) + CW'(slip_q);
        pop       = ({1'b0, cnt_q} >= take);
        popped    = pop ? take : '0;
        after_pop = {1'b0, cnt_q} - popped;
        ready     = !i_rst && ((after_pop + CW'(IN_W)) <= CW'(CAP));
        push      = bus.i_valid && ready;
        cnt_d     = LVL_W'(after_pop + (push ? CW'(IN_W) : '0));
        // Pulses are ignored while a slip is pending.
        // A pulse on the pop edge arms the following pop.
        slip_d    = slip_q ? !pop : bus.i_bitslip;
    end

    // Put each incoming lane symbol into transmit order, so bit 0 always leaves first.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            for (int i = 0; i < IN_W; i++) begin
                sym[c][i] = (LSB_FIRST != 0) ? bus.i_pdata[c*IN_W + i]
                                             : bus.i_pdata[c*IN_W + IN_W - 1 - i];
            end
        end
    end

    // Per-lane buffer update and beat extraction.
    // When a slip is pending, the oldest bit is skipped.
    always_comb begin
        sdata_d = sdata_q;
        for (int c = 0; c < NUM_CH; c++) begin
            buf_d[c] = pop ? (buf_q[c] >> take) : buf_q[c];
            if (push) begin
                buf_d[c] = buf_d[c] | (CAP'(sym[c]) << after_pop);
            end
            if (pop) begin
                for (int i = 0; i < OUT_W; i++) begin
                    sdata_d[c*OUT_W + i] = slip_q ? buf_q[c][i+1] : buf_q[c][i];
                end
            end
        end
    end

    // FSM next state: FILL becomes RUN on the first pop.
    // A pop miss while in RUN flags underflow and drops back to FILL.
    always_comb begin
        state_d     = state_q;
        underflow_d = underflow_q;
        case (state_q)
            ST_FILL: begin
                if (pop) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!pop) begin
                    state_d     = ST_FILL;
                    underflow_d = 1'b1;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    // FSM state register and sticky underflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_FILL;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            underflow_q <= underflow_d;
        end
    end

    // Datapath registers: level, slip pending, lane buffers and output beat.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q         <= '0;
            slip_q        <= 1'b0;
            sdata_q       <= '0;
            sdata_valid_q <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                buf_q[c] <= '0;
            end
        end else begin
            cnt_q         <= cnt_d;
            slip_q        <= slip_d;
            sdata_q       <= sdata_d;
            sdata_valid_q <= pop;
            for (int c = 0; c < NUM_CH; c++) begin
                buf_q[c] <= buf_d[c];
            end
        end
    end

    assign bus.o_ready       = ready;
    assign bus.o_sdata       = sdata_q;
    assign bus.o_sdata_valid = sdata_valid_q;
    assign bus.o_underflow   = underflow_q;
    assign bus.o_level       = cnt_q;

endmodule

// File: tb/tb_tmds_gearbox.sv
// Scoreboard bench for tmds_gearbox.
// Instance A (4 lanes, 10->4, LSB first) is checked against a per-lane bit
// queue that is filled on every accepted push. Instance B (1 lane, 10->10,
// MSB first) is checked against a table of hand-reversed symbols.
module tb_tmds_gearbox;
    localparam int NCH = 4;
    localparam int IW  = 10;
    localparam int OW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tmds_gearbox_if #(.NUM_CH(NCH), .IN_W(IW), .OUT_W(OW)) bus_a ();
    tmds_gearbox_if #(.NUM_CH(1),   .IN_W(10), .OUT_W(10)) bus_b ();

    tmds_gearbox #(.NUM_CH(NCH), .IN_W(IW), .OUT_W(OW), .LSB_FIRST(1)) dut_a (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_a)
    );

    tmds_gearbox #(.NUM_CH(1), .IN_W(10), .OUT_W(10), .LSB_FIRST(0)) dut_b (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus_b)
    );

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;

    bit          q_bits [NCH][$];
    bit          slip_pend_m = 1'b0;
    int          slip_edge = 0;
    logic [IW-1:0] lane_v [NCH];
    bit          alt0 = 1'b0;
    bit          acc_a;
    bit          sv_seen;
    int          n_acc = 0;

    bit          cap_en = 1'b0;
    int          ncap = 0;
    logic [OW-1:0] beats [10][NCH];

    logic [9:0]  expb_d [$];
    int          expb_e [$];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Monitor A: every beat must match the oldest modelled bits.
    // On the first beat popped after the slip edge, one bit is dropped first.
    always @(negedge clk) begin
        if (bus_a.o_sdata_valid) begin
            if (slip_pend_m && edge_cnt > slip_edge) begin
                for (int c = 0; c < NCH; c++) begin
                    if (q_bits[c].size() > 0) void'(q_bits[c].pop_front());
                end
                slip_pend_m = 1'b0;
            end
            for (int c = 0; c < NCH; c++) begin
                if (q_bits[c].size() < OW) begin
                    checks++;
                    errors++;
                    $display("FAIL a_underrun lane %0d: have %0d bits need %0d", c, q_bits[c].size(), OW);
                end else begin
                    logic [OW-1:0] e;
                    for (int i = 0; i < OW; i++) e[i] = q_bits[c].pop_front();
                    chk($sformatf("a_beat_lane%0d", c), 64'(bus_a.o_sdata[c*OW +: OW]), 64'(e));
                end
            end
            if (cap_en && ncap < 10) begin
                for (int c = 0; c < NCH; c++) beats[ncap][c] = bus_a.o_sdata[c*OW +: OW];
                ncap++;
            end
        end
    end

    // Monitor B: each beat must equal the reversed symbol and appear one edge after its accept.
    always @(negedge clk) begin
        if (bus_b.o_sdata_valid) begin
            if (expb_d.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_spurious: beat %0h with nothing expected", bus_b.o_sdata);
            end else begin
                logic [9:0] d;
                int e;
                d = expb_d.pop_front();
                e = expb_e.pop_front();
                chk("b_beat", 64'(bus_b.o_sdata), 64'(d));
                chk("b_latency_edge", 64'(edge_cnt), 64'(e + 1));
            end
        end
    end

    task automatic step_a(input bit v, input bit slip);
        for (int c = 0; c < NCH; c++) bus_a.i_pdata[c*IW +: IW] = lane_v[c];
        bus_a.i_valid   = v;
        bus_a.i_bitslip = slip;
        @(negedge clk);
        #1;
        acc_a   = v && bus_a.o_ready && !rst;
        sv_seen = bus_a.o_sdata_valid;
        if (acc_a) begin
            for (int c = 0; c < NCH; c++)
                for (int i = 0; i < IW; i++) q_bits[c].push_back(lane_v[c][i]);
            n_acc++;
        end
        if (slip && !rst && !slip_pend_m) begin
            slip_pend_m = 1'b1;
            slip_edge   = edge_cnt + 1;
        end
        if (rst) begin
            for (int c = 0; c < NCH; c++) q_bits[c].delete();
            slip_pend_m = 1'b0;
        end
        @(posedge clk);
        #1;
        if (acc_a && alt0) lane_v[0] = ~lane_v[0];
    endtask

    task automatic step_b(input bit v, input logic [9:0] sym, input logic [9:0] exp_rev);
        bus_b.i_pdata   = sym;
        bus_b.i_valid   = v;
        bus_b.i_bitslip = 1'b0;
        @(negedge clk);
        #1;
        if (v) begin
            chk("b_ready_steady", 64'(bus_b.o_ready), 64'd1);
            if (bus_b.o_ready && !rst) begin
                expb_d.push_back(exp_rev);
                expb_e.push_back(edge_cnt + 1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [3:0] t0 [5];
    logic [9:0] bsym [4];
    logic [9:0] brev [4];
    bit         saw_low;
    int         acc_win;

    initial begin
        t0   = '{4'hF, 4'hF, 4'h3, 4'h0, 4'h0};
        bsym = '{10'h001, 10'h0F0, 10'h155, 10'h3C1};
        brev = '{10'h200, 10'h03C, 10'h2AA, 10'h20F};
        bus_a.i_pdata = '0; bus_a.i_valid = 1'b0; bus_a.i_bitslip = 1'b0;
        bus_b.i_pdata = '0; bus_b.i_valid = 1'b0; bus_b.i_bitslip = 1'b0;
        for (int c = 0; c < NCH; c++) lane_v[c] = '0;

        // Reset state.
        rst = 1'b1;
        repeat (3) step_a(1'b0, 1'b0);
        chk("rst_level", 64'(bus_a.o_level), 64'd0);
        chk("rst_sdata", 64'(bus_a.o_sdata), 64'd0);
        chk("rst_sdata_valid", 64'(bus_a.o_sdata_valid), 64'd0);
        chk("rst_underflow", 64'(bus_a.o_underflow), 64'd0);
        chk("rst_ready_low", 64'(bus_a.o_ready), 64'd0);
        rst = 1'b0;

        // Lane 0 alternates 3FF/000, lanes 1-3 carry fixed patterns.
        lane_v[0] = 10'h3FF; lane_v[1] = 10'h155; lane_v[2] = 10'h2AA; lane_v[3] = 10'h000;
        alt0 = 1'b1;
        cap_en = 1'b1;
        acc_win = 0;
        for (int i = 0; i < 30; i++) begin
            step_a(1'b1, 1'b0);
            if (i >= 6 && i <= 15 && acc_a) acc_win++;
        end
        chk("ready_duty_10cyc", 64'(acc_win), 64'd4);
        chk("no_underflow_stream", 64'(bus_a.o_underflow), 64'd0);
        chk("captured_beats", 64'(ncap), 64'd10);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("dir_lane0_beat%0d", i), 64'(beats[i][0]), 64'(t0[i % 5]));
            chk($sformatf("dir_lane1_beat%0d", i), 64'(beats[i][1]), 64'h5);
            chk($sformatf("dir_lane2_beat%0d", i), 64'(beats[i][2]), 64'hA);
            chk($sformatf("dir_lane3_beat%0d", i), 64'(beats[i][3]), 64'h0);
        end
        cap_en = 1'b0;

        // Starve while in RUN.
        saw_low = 1'b0;
        repeat (8) begin
            step_a(1'b0, 1'b0);
            if (!sv_seen) saw_low = 1'b1;
        end
        chk("underflow_set", 64'(bus_a.o_underflow), 64'd1);
        chk("sdata_valid_low_in_starve", 64'(saw_low), 64'd1);
        repeat (20) step_a(1'b1, 1'b0);
        chk("underflow_sticky", 64'(bus_a.o_underflow), 64'd1);

        // Single bitslip on a 0x001 stream.
        alt0 = 1'b0;
        for (int c = 0; c < NCH; c++) lane_v[c] = 10'h001;
        repeat (15) step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b1);
        repeat (25) step_a(1'b1, 1'b0);
        chk("slip_consumed", 64'(slip_pend_m), 64'd0);

        // Mid-stream reset with a slip still pending.
        lane_v[0] = 10'h155; lane_v[1] = 10'h2AA; lane_v[2] = 10'h3FF; lane_v[3] = 10'h000;
        repeat (12) step_a(1'b1, 1'b0);
        step_a(1'b1, 1'b1);
        rst = 1'b1;
        step_a(1'b1, 1'b0);
        rst = 1'b0;
        chk("rst2_level", 64'(bus_a.o_level), 64'd0);
        chk("rst2_sdata", 64'(bus_a.o_sdata), 64'd0);
        chk("rst2_sdata_valid", 64'(bus_a.o_sdata_valid), 64'd0);
        chk("rst2_underflow", 64'(bus_a.o_underflow), 64'd0);
        lane_v[0] = 10'h0F0; lane_v[1] = 10'h155; lane_v[2] = 10'h2AA; lane_v[3] = 10'h000;
        ncap = 0;
        cap_en = 1'b1;
        repeat (15) step_a(1'b1, 1'b0);
        cap_en = 1'b0;
        chk("refill_lane0_beat0", 64'(beats[0][0]), 64'h0);
        chk("refill_lane0_beat1", 64'(beats[1][0]), 64'hF);
        chk("refill_lane0_beat2", 64'(beats[2][0]), 64'h0);
        chk("refill_lane1_beat0", 64'(beats[0][1]), 64'h5);
        chk("refill_lane2_beat0", 64'(beats[0][2]), 64'hA);

        // Drain A and compare the leftover level with the model.
        repeat (10) step_a(1'b0, 1'b0);
        chk("drain_level", 64'(bus_a.o_level), 64'(q_bits[0].size()));

        // 10->10 MSB-first pass-through.
        for (int i = 0; i < 4; i++) step_b(1'b1, bsym[i], brev[i]);
        repeat (3) step_b(1'b0, 10'h000, 10'h000);
        chk("b_queue_drained", 64'(expb_d.size()), 64'd0);
        chk("b_level_idle", 64'(bus_b.o_level), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end
endmodule
